// File: rtl/sya_act_skew_feeder_if.sv
// Bundle between the activation source, the skew feeder and the PE array's left edge.
// The source drives the master side; the feeder is the slave.
interface sya_act_skew_feeder_if #(
    parameter int unsigned NUM_ROW     = 16,
    parameter int unsigned ACT_WIDTH   = 8,
    parameter int unsigned DEPTH_WIDTH = 12
);
    logic                         cfg_start;
    logic [DEPTH_WIDTH-1:0]       cfg_depth;
    logic [DEPTH_WIDTH-1:0]       cfg_num_grp;
    logic [NUM_ROW*ACT_WIDTH-1:0] in_act;
    logic                         in_vld;
    logic                         in_rdy;
    logic                         array_rdy;
    logic [NUM_ROW*ACT_WIDTH-1:0] out_act;
    logic [NUM_ROW-1:0]           out_vld;
    logic [NUM_ROW-1:0]           out_acc_reset;
    logic                         busy;
    logic                         done;

    modport master (
        output cfg_start, cfg_depth, cfg_num_grp, in_act, in_vld, array_rdy,
        input  in_rdy, out_act, out_vld, out_acc_reset, busy, done
    );

    modport slave (
        input  cfg_start, cfg_depth, cfg_num_grp, in_act, in_vld, array_rdy,
        output in_rdy, out_act, out_vld, out_acc_reset, busy, done
    );
endinterface

// File: rtl/sya_act_skew_feeder.sv
// Systolic-array activation feeder: skews row r by r cycles, sequences K*N beats plus a flush.
// Build option SYA_FEED_ZERO_GATE_EN: bubbles inject act=0 instead of the raw in_act.
module sya_act_skew_feeder #(
    parameter int unsigned NUM_ROW     = 16,
    parameter int unsigned ACT_WIDTH   = 8,
    parameter int unsigned DEPTH_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sya_act_skew_feeder_if.slave  feed
);

    localparam int unsigned DrainW = (NUM_ROW > 2) ? $clog2(NUM_ROW) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'((NUM_ROW >= 2) ? NUM_ROW - 2 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFlush,
        StDrain,
        StDone
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [DEPTH_WIDTH-1:0] r_depth;
    logic [DEPTH_WIDTH-1:0] w_depth_nxt;
    logic [DEPTH_WIDTH-1:0] r_num_grp;
    logic [DEPTH_WIDTH-1:0] w_num_grp_nxt;
    logic [DEPTH_WIDTH-1:0] r_k;
    logic [DEPTH_WIDTH-1:0] w_k_nxt;
    logic [DEPTH_WIDTH-1:0] r_g;
    logic [DEPTH_WIDTH-1:0] w_g_nxt;
    logic [DrainW-1:0]      r_drain;
    logic [DrainW-1:0]      w_drain_nxt;

    logic w_adv;
    logic w_in_rdy;
    logic w_inj_vld;
    logic w_inj_acc;
    logic w_inj_zero;

    logic [NUM_ROW-1:0][ACT_WIDTH-1:0] w_out_act;
    logic [NUM_ROW-1:0]                w_out_vld;
    logic [NUM_ROW-1:0]                w_out_acc;

    // The whole array advances in lockstep with the rows' left-edge ready.
    assign w_adv = feed.array_rdy;

    always_comb begin
        w_state_nxt   = r_state;
        w_depth_nxt   = r_depth;
        w_num_grp_nxt = r_num_grp;
        w_k_nxt       = r_k;
        w_g_nxt       = r_g;
        w_drain_nxt   = r_drain;
        w_in_rdy      = 1'b0;
        w_inj_vld     = 1'b0;
        w_inj_acc     = 1'b0;
`ifdef SYA_FEED_ZERO_GATE_EN
        w_inj_zero    = 1'b1;
`else
        w_inj_zero    = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (feed.cfg_start) begin
                    w_depth_nxt   = (feed.cfg_depth == '0) ? DEPTH_WIDTH'(1) : feed.cfg_depth;
                    w_num_grp_nxt = feed.cfg_num_grp;
                    w_k_nxt       = '0;
                    w_g_nxt       = '0;
                    w_drain_nxt   = '0;
                    w_state_nxt   = (feed.cfg_num_grp == '0) ? StFlush : StRun;
                end
            end
            StRun: begin
                w_in_rdy = feed.array_rdy;
                if (feed.in_vld && feed.array_rdy) begin
                    w_inj_vld  = 1'b1;
                    w_inj_acc  = (r_k == '0);
                    w_inj_zero = 1'b0;
                    if (r_k == r_depth - DEPTH_WIDTH'(1)) begin
                        w_k_nxt = '0;
                        if (r_g == r_num_grp - DEPTH_WIDTH'(1)) begin
                            w_state_nxt = StFlush;
                        end else begin
                            w_g_nxt = r_g + DEPTH_WIDTH'(1);
                        end
                    end else begin
                        w_k_nxt = r_k + DEPTH_WIDTH'(1);
                    end
                end
            end
            StFlush: begin
                w_inj_acc  = 1'b1;
                w_inj_zero = 1'b1;
                if (w_adv) begin
                    w_state_nxt = (NUM_ROW > 1) ? StDrain : StDone;
                end
            end
            StDrain: begin
                if (w_adv) begin
                    if (r_drain == DrainLast) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_drain_nxt = r_drain + DrainW'(1);
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_depth   <= '0;
            r_num_grp <= '0;
            r_k       <= '0;
            r_g       <= '0;
            r_drain   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_depth   <= w_depth_nxt;
            r_num_grp <= w_num_grp_nxt;
            r_k       <= w_k_nxt;
            r_g       <= w_g_nxt;
            r_drain   <= w_drain_nxt;
        end
    end

    // Row r is an (r+1)-deep chain; stage 0 takes the injected entry.
    for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
        logic [ACT_WIDTH-1:0] r_act [r+1];
        logic [r:0]           r_vld;
        logic [r:0]           r_acc;
        logic [ACT_WIDTH-1:0] w_inj_act;

        assign w_inj_act = w_inj_zero ? '0 : feed.in_act[r*ACT_WIDTH +: ACT_WIDTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= r; j++) begin
                    r_act[j] <= '0;
                end
                r_vld <= '0;
                r_acc <= '0;
            end else if (w_adv) begin
                r_act[0] <= w_inj_act;
                r_vld[0] <= w_inj_vld;
                r_acc[0] <= w_inj_acc;
                for (int j = 1; j <= r; j++) begin
                    r_act[j] <= r_act[j-1];
                    r_vld[j] <= r_vld[j-1];
                    r_acc[j] <= r_acc[j-1];
                end
            end
        end

        assign w_out_act[r] = r_act[r];
        assign w_out_vld[r] = r_vld[r];
        assign w_out_acc[r] = r_acc[r];
    end

    assign feed.out_act       = w_out_act;
    assign feed.out_vld       = w_out_vld;
    assign feed.out_acc_reset = w_out_acc;
    assign feed.in_rdy        = w_in_rdy;
    assign feed.busy          = (r_state != StIdle);
    assign feed.done          = (r_state == StDone);

endmodule

// File: tb/tb_sya_act_skew_feeder.sv
// Scoreboard bench for sya_act_skew_feeder: a job-level model queues per-row expected entries,
// a monitor pops and compares them as each row presents vld or acc_reset.
module tb_sya_act_skew_feeder;
    localparam int unsigned NR = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 12;

    localparam int PIdle  = 0;
    localparam int PRun   = 1;
    localparam int PFlush = 2;
    localparam int PDrain = 3;
    localparam int PDone  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sya_act_skew_feeder_if #(.NUM_ROW(NR), .ACT_WIDTH(AW), .DEPTH_WIDTH(DW)) bus ();

    sya_act_skew_feeder #(.NUM_ROW(NR), .ACT_WIDTH(AW), .DEPTH_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .feed  (bus)
    );

    typedef struct {
        logic [AW-1:0] act;
        bit            vld;
        bit            acc;
        int            t;
    } ent_t;

    ent_t exp_q [NR][$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_adv = 0;
    int   phase = PIdle;
    int   m_k, m_total, m_beat, m_drain_left;
    int   dut_done_cnt = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [AW-1:0] a [NR], input bit vld, input bit acc);
        for (int r = 0; r < NR; r++) begin
            ent_t e;
            e.act = a[r];
            e.vld = vld;
            e.acc = acc;
            e.t   = m_adv + r;
            exp_q[r].push_back(e);
        end
    endtask

    // One cycle: drive at negedge, check control outputs, then advance the model over the edge.
    task automatic step(input bit start, input int dep, input int ngrp, input bit vld,
                        input bit rdy, input int mode);
        logic [AW-1:0] a [NR];
        logic [AW-1:0] z [NR];
        @(negedge clk);
        bus.cfg_start   = start;
        bus.cfg_depth   = DW'(dep);
        bus.cfg_num_grp = DW'(ngrp);
        bus.in_vld      = vld;
        bus.array_rdy   = rdy;
        for (int r = 0; r < NR; r++) begin
            a[r] = (mode == 1) ? AW'(16 * m_beat + r) : AW'($urandom);
            z[r] = '0;
            bus.in_act[r*AW +: AW] = a[r];
        end
        #1;
        chk("in_rdy", bus.in_rdy, (phase == PRun) && rdy);
        chk("busy", bus.busy, phase != PIdle);
        chk("done", bus.done, phase == PDone);
        if (bus.done === 1'b1) dut_done_cnt++;
        if (rdy) m_adv++;
        case (phase)
            PIdle: if (start) begin
                m_k     = (dep == 0) ? 1 : dep;
                m_total = m_k * ngrp;
                m_beat  = 0;
                phase   = (ngrp == 0) ? PFlush : PRun;
            end
            PRun: if (rdy && vld) begin
                push(a, 1'b1, (m_beat % m_k) == 0);
                m_beat++;
                if (m_beat == m_total) phase = PFlush;
            end
            PFlush: if (rdy) begin
                push(z, 1'b0, 1'b1);
                m_drain_left = NR - 1;
                phase = (NR > 1) ? PDrain : PDone;
            end
            PDrain: if (rdy) begin
                m_drain_left--;
                if (m_drain_left == 0) phase = PDone;
            end
            default: phase = PIdle;
        endcase
    endtask

    task automatic run_job(input int dep, input int ngrp, input int vld_mode, input int rdy_mode,
                           input int act_mode);
        int cyc = 0;
        bit v, rd;
        dut_done_cnt = 0;
        step(1'b1, dep, ngrp, 1'b1, 1'b1, act_mode);
        while (phase != PIdle && cyc < 3000) begin
            v  = (vld_mode == 0) ? 1'b1 : (vld_mode == 1) ? (cyc % 2 == 1) : ($urandom_range(0, 3) != 0);
            rd = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? !(cyc >= 2 && cyc < 7)
                                        : ($urandom_range(0, 3) != 0);
            // A second start with different configuration mid-job must be ignored.
            step(cyc == 1, dep + 3, ngrp + 1, v, rd, act_mode);
            cyc++;
        end
        if (cyc >= 3000) begin
            n_vec++;
            n_bad++;
            $display("FAIL job_timeout: job K=%0d N=%0d still active after %0d cycles", dep, ngrp, cyc);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1, 0);
        chk("done_pulses", dut_done_cnt, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.array_rdy = 1'b0;
        bus.cfg_start = 1'b0;
        bus.in_vld    = 1'b0;
        #1;
        chk("rst_outputs", {bus.out_act, bus.out_vld, bus.out_acc_reset}, '0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_in_rdy", bus.in_rdy, 1'b0);
        for (int r = 0; r < NR; r++) exp_q[r].delete();
        phase = PIdle;
        m_adv = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: on advancing edges pop/compare per row; on stalled edges outputs must hold.
    logic [NR*AW-1:0] p_act = '0;
    logic [NR-1:0]    p_vld = '0;
    logic [NR-1:0]    p_acc = '0;
    always @(posedge clk) begin
        bit   adv;
        ent_t e;
        adv = bus.array_rdy;
        #1;
        if (rst_n) begin
            if (!adv) begin
                chk("stall_hold", {bus.out_act, bus.out_vld, bus.out_acc_reset},
                    {p_act, p_vld, p_acc});
            end else begin
                for (int r = 0; r < NR; r++) begin
                    if (bus.out_vld[r] || bus.out_acc_reset[r]) begin
                        if (exp_q[r].size() == 0) begin
                            chk($sformatf("row%0d_extra", r), {bus.out_vld[r], bus.out_acc_reset[r]}, 0);
                        end else begin
                            e = exp_q[r].pop_front();
                            chk($sformatf("row%0d_time", r), m_adv, e.t);
                            chk($sformatf("row%0d_vld", r), bus.out_vld[r], e.vld);
                            chk($sformatf("row%0d_acc", r), bus.out_acc_reset[r], e.acc);
                            chk($sformatf("row%0d_act", r), bus.out_act[r*AW +: AW], e.act);
                        end
                    end else if (exp_q[r].size() > 0 && exp_q[r][0].t <= m_adv) begin
                        e = exp_q[r].pop_front();
                        chk($sformatf("row%0d_missing", r), {bus.out_vld[r], bus.out_acc_reset[r]},
                            {e.vld, e.acc});
                    end
                end
            end
        end
        p_act = bus.out_act;
        p_vld = bus.out_vld;
        p_acc = bus.out_acc_reset;
    end

    initial begin
        int guard;
        bus.cfg_start   = 1'b0;
        bus.cfg_depth   = '0;
        bus.cfg_num_grp = '0;
        bus.in_act      = '0;
        bus.in_vld      = 1'b0;
        bus.array_rdy   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs", {bus.out_act, bus.out_vld, bus.out_acc_reset}, '0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;

        run_job(3, 1, 0, 0, 0);   // basic
        run_job(2, 2, 0, 0, 1);   // skew pattern 16*beat+r
        run_job(4, 1, 1, 0, 0);   // bubbles every other cycle
        run_job(5, 2, 0, 1, 0);   // 5-cycle stall mid-RUN
        run_job(0, 1, 0, 0, 0);   // K=0 acts as K=1
        run_job(0, 0, 0, 0, 0);   // N=0: flush only
        for (int i = 0; i < 6; i++) begin
            run_job($urandom_range(0, 5), $urandom_range(0, 3), 2, 2, 0);
        end

        // Abort in the middle of DRAIN, then confirm a clean job follows.
        dut_done_cnt = 0;
        step(1'b1, 2, 1, 1'b1, 1'b1, 0);
        guard = 0;
        while (!(phase == PDrain && m_drain_left == 8) && guard < 200) begin
            step(1'b0, 0, 0, 1'b1, 1'b1, 0);
            guard++;
        end
        do_reset();
        chk("abort_no_done", dut_done_cnt, 0);
        run_job(3, 2, 2, 2, 0);

        repeat (20) step(1'b0, 0, 0, 1'b0, 1'b1, 0);
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("row%0d_leftover", r), exp_q[r].size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
